// File: rtl/alu_exec_stage.sv
// LC-3 execute stage: ADD/AND/NOT/PASS, NZP and BEN, one-entry output buffer.
// Optional iterative multiply on opcode 1101 when ALU_MUL_EN is defined.
module alu_exec_stage #(
    parameter int         DATA_W    = 16,
    parameter logic [2:0] NZP_RESET = 3'b010
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [15:0]       IR,
    input  logic [DATA_W-1:0] SR1_IN,
    input  logic [DATA_W-1:0] SR2_IN,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Result,
    output logic [2:0]        NZP,
    output logic              BEN
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_result;
    logic [2:0]        r_nzp;
    logic              r_ben;

    logic [3:0]        w_op;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_opb;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_load_val;
    logic [2:0]        w_res_nzp;
    logic              w_accept;
    logic              w_is_br;
    logic              w_is_mul;
    logic              w_upd;
    logic              w_load;
    logic              w_nzp_upd;
    logic              w_unused;

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(DATA_W);
    logic [DATA_W-1:0] r_mul_a;
    logic [DATA_W-1:0] r_mul_b;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
`endif

    assign w_op     = IR[15:12];
    assign w_imm    = {{(DATA_W-5){IR[4]}}, IR[4:0]};
    assign w_opb    = IR[5] ? w_imm : SR2_IN;
    assign w_unused = ^IR[8:6];

    assign In_Ready  = (r_state == S_IDLE) & (~r_out_valid | Out_Ready);
    assign w_accept  = In_Valid & In_Ready;
    assign Out_Valid = r_out_valid;
    assign Result    = r_result;
    assign NZP       = r_nzp;
    assign BEN       = r_ben;

    always_comb begin
        w_alu    = SR1_IN;
        w_is_br  = 1'b0;
        w_is_mul = 1'b0;
        w_upd    = 1'b0;
        unique case (1'b1)
            (w_op == 4'b0001): begin
                w_alu = SR1_IN + w_opb;
                w_upd = 1'b1;
            end
            (w_op == 4'b0101): begin
                w_alu = SR1_IN & w_opb;
                w_upd = 1'b1;
            end
            (w_op == 4'b1001): begin
                w_alu = ~SR1_IN;
                w_upd = 1'b1;
            end
            (w_op == 4'b0000): w_is_br = 1'b1;
`ifdef ALU_MUL_EN
            (w_op == 4'b1101): w_is_mul = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = w_alu;
        w_nzp_upd   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_is_br) begin
                    if (w_is_mul) begin
                        w_state_nxt = S_MUL;
                    end else begin
                        w_load    = 1'b1;
                        w_nzp_upd = w_upd;
                    end
                end
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                if (r_cnt == '0) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_load      = 1'b1;
                w_load_val  = r_acc;
                w_nzp_upd   = 1'b1;
                w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        if (w_load_val[DATA_W-1]) w_res_nzp = 3'b100;
        else if (w_load_val == '0) w_res_nzp = 3'b010;
        else w_res_nzp = 3'b001;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_nzp       <= NZP_RESET;
            r_ben       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // a same-edge load keeps the buffer full even while draining
            if (w_load) begin
                r_result    <= w_load_val;
                r_out_valid <= 1'b1;
            end else if (Out_Ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_nzp_upd) r_nzp <= w_res_nzp;
            if (w_accept && w_is_br) r_ben <= |(IR[11:9] & r_nzp);
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_accept && w_is_mul) begin
                r_mul_a <= SR1_IN;
                r_mul_b <= w_opb;
                r_acc   <= '0;
                r_cnt   <= CNT_W'(DATA_W - 1);
            end
        end else if (r_state == S_MUL) begin
            if (r_mul_b[0]) r_acc <= r_acc + r_mul_a;
            r_mul_a <= r_mul_a << 1;
            r_mul_b <= r_mul_b >> 1;
            r_cnt   <= r_cnt - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage.
// Define ALU_MUL_EN to exercise the multiply path as well.
module tb_alu_exec_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        In_Valid;
    logic        In_Ready;
    logic [15:0] IR;
    logic [15:0] SR1_IN;
    logic [15:0] SR2_IN;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [15:0] Result;
    logic [2:0]  NZP;
    logic        BEN;

    int n_chk = 0;
    int n_err = 0;

    alu_exec_stage #(.DATA_W(16), .NZP_RESET(3'b010)) dut (
        .Clk(Clk), .Reset(Reset),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .IR(IR), .SR1_IN(SR1_IN), .SR2_IN(SR2_IN),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Result(Result), .NZP(NZP), .BEN(BEN)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] ir, input logic [15:0] a,
                         input logic [15:0] b);
        In_Valid = 1'b1;
        IR       = ir;
        SR1_IN   = a;
        SR2_IN   = b;
    endtask

    initial begin
        Reset = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
        IR = '0; SR1_IN = '0; SR2_IN = '0;
        step();
        step();
        chk("rst_ov",  Out_Valid, 0);
        chk("rst_res", Result, 16'h0000);
        chk("rst_nzp", NZP, 3'b010);
        chk("rst_ben", BEN, 0);
        chk("rst_ir",  In_Ready, 1);

        Reset = 1'b1; Out_Ready = 1'b1;
        issue(16'h1262, 16'h7FFF, 16'h0000);
        step();
        chk("add_ov",  Out_Valid, 1);
        chk("add_res", Result, 16'h8001);
        chk("add_nzp", NZP, 3'b100);

        issue(16'h5002, 16'h00F0, 16'h0F0F);
        step();
        chk("and_res", Result, 16'h0000);
        chk("and_nzp", NZP, 3'b010);
        chk("and_ov",  Out_Valid, 1);

        issue(16'h0400, 16'h0000, 16'h0000);
        step();
        chk("brz_ben", BEN, 1);
        chk("brz_ov",  Out_Valid, 0);
        chk("brz_res", Result, 16'h0000);

        issue(16'h0800, 16'h0000, 16'h0000);
        step();
        chk("brn_ben", BEN, 0);

        issue(16'h903F, 16'h0000, 16'h1234);
        step();
        chk("not_res", Result, 16'hFFFF);
        chk("not_nzp", NZP, 3'b100);
        In_Valid = 1'b0; Out_Ready = 1'b0;
        #1;
        chk("bp_ir", In_Ready, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_res", Result, 16'hFFFF);
            chk("bp_ov",  Out_Valid, 1);
            chk("bp_ir",  In_Ready, 0);
        end
        Out_Ready = 1'b1;
        issue(16'h1020, 16'h0005, 16'h0000);
        #1;
        chk("bp_rel_ir", In_Ready, 1);
        step();
        chk("same_edge_ov",  Out_Valid, 1);
        chk("same_edge_res", Result, 16'h0005);
        chk("same_edge_nzp", NZP, 3'b001);

        for (int i = 0; i < 5; i++) begin
            issue(16'h1021, 16'(i * 16'h0100), 16'h0000);
            step();
            chk("b2b_res", Result, 32'(i * 16'h0100 + 1));
            chk("b2b_ov",  Out_Valid, 1);
            chk("b2b_ir",  In_Ready, 1);
        end

        issue(16'h1000, 16'h8000, 16'h8000);
        step();
        chk("carry_res", Result, 16'h0000);
        chk("carry_nzp", NZP, 3'b010);

        issue(16'h103F, 16'h0000, 16'h0000);
        step();
        chk("neg_res", Result, 16'hFFFF);
        chk("neg_nzp", NZP, 3'b100);

        issue(16'h0800, 16'h0000, 16'h0000);
        step();
        chk("br_after_add", BEN, 1);
        chk("br_after_ov",  Out_Valid, 0);

        issue(16'h3000, 16'h1234, 16'h0000);
        step();
        chk("pass_res", Result, 16'h1234);
        chk("pass_nzp", NZP, 3'b100);
        chk("pass_ov",  Out_Valid, 1);

        In_Valid = 1'b0;
        step();
        chk("drain_ov", Out_Valid, 0);

`ifdef ALU_MUL_EN
        begin
            int n;
            issue(16'hD000, 16'h0003, 16'h0005);
            step();
            In_Valid = 1'b0;
            chk("mul_ir", In_Ready, 0);
            n = 0;
            while (!Out_Valid && n < 40) begin
                step();
                n++;
            end
            chk("mul_lat", n, 17);
            chk("mul_res", Result, 16'h000F);
            chk("mul_nzp", NZP, 3'b001);

            step();
            issue(16'hD000, 16'h0003, 16'h0005);
            step();
            In_Valid = 1'b0;
            for (int i = 0; i < 5; i++) step();
            Reset = 1'b0;
            step();
            Reset = 1'b1;
            for (int i = 0; i < 20; i++) begin
                step();
                chk("mul_abort_ov", Out_Valid, 0);
            end
            chk("mul_abort_nzp", NZP, 3'b010);
            chk("mul_abort_ir",  In_Ready, 1);
        end
`else
        issue(16'hD000, 16'h0042, 16'h0005);
        step();
        In_Valid = 1'b0;
        chk("op_d_res", Result, 16'h0042);
        chk("op_d_ov",  Out_Valid, 1);
        chk("op_d_nzp", NZP, 3'b100);
        chk("op_d_ir",  In_Ready, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
